// File: rtl/square_freq_meter.sv
// square_freq_meter: measures the period of an asynchronous square wave in
// clk cycles. Each result is the average over 2^AVG_LOG2 consecutive periods.
// The meter flags loss of signal after TIMEOUT cycles with no rising edge.
// Optional duty measurement: define DUTY_MEAS_EN to also report the averaged
// high-phase length on high_time. Without it, high_time is tied to 0.
module square_freq_meter #(
  parameter int CNT_W    = 24,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             no_signal,
  output logic [CNT_W-1:0] high_time
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NPER_W-1:0] NPER_LAST   = NPER_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic               s1_reg, s2_reg, s3_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [NPER_W-1:0]  nper_reg, nper_next;
  logic [CNT_W-1:0]   period_reg, period_next;
  logic               vld_reg, vld_next;
  logic               nosig_reg, nosig_next;
  logic [ACC_W-1:0]   acc_sum;
  logic               rise;
  logic               timeout;
  logic               window_done;

  assign rise        = s2_reg & ~s3_reg;
  // A rise in the same cycle as the timeout count keeps the measurement alive.
  assign timeout     = (cnt_reg == TIMEOUT_CNT) && !rise;
  assign window_done = (state_reg == MEASURE) && rise && (nper_reg == NPER_LAST);
  assign acc_sum     = acc_reg + ACC_W'(cnt_reg);

  assign period     = period_reg;
  assign period_vld = vld_reg;
  assign no_signal  = nosig_reg;

  // Synchronizer chain; s3 is the one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= sig_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // Cycles since the last rise; restarts at 1 on a rise and saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (rise) begin
      cnt_reg <= CNT_W'(1);
    end else if (cnt_reg != {CNT_W{1'b1}}) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // FSM state and measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      nper_reg   <= '0;
      period_reg <= '0;
      vld_reg    <= 1'b0;
      nosig_reg  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      nper_reg   <= nper_next;
      period_reg <= period_next;
      vld_reg    <= vld_next;
      nosig_reg  <= nosig_next;
    end
  end

  // Next-state logic. Window accumulation happens on rises, and the timeout overrides everything.
  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    nper_next   = nper_reg;
    period_next = period_reg;
    vld_next    = 1'b0;
    nosig_next  = nosig_reg;

    case (state_reg)
      IDLE: begin
        // The first edge only opens a window; it has no preceding period.
        if (rise) begin
          state_next = MEASURE;
          acc_next   = '0;
          nper_next  = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          if (nper_reg == NPER_LAST) begin
            // This rise closes the window and also opens the next one.
            period_next = acc_sum[AVG_LOG2 +: CNT_W];
            vld_next    = 1'b1;
            nosig_next  = 1'b0;
            acc_next    = '0;
            nper_next   = '0;
          end else begin
            acc_next  = acc_sum;
            nper_next = nper_reg + NPER_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (timeout) begin
      state_next  = IDLE;
      acc_next    = '0;
      nper_next   = '0;
      period_next = '0;
      vld_next    = 1'b0;
      nosig_next  = 1'b1;
    end
  end

`ifdef DUTY_MEAS_EN
  logic [ACC_W-1:0] hacc_reg, hacc_next;
  logic [CNT_W-1:0] high_reg, high_next;

  assign high_time = high_reg;

  // Duty accumulator and reported high time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hacc_reg <= '0;
      high_reg <= '0;
    end else begin
      hacc_reg <= hacc_next;
      high_reg <= high_next;
    end
  end

  // Count high cycles in MEASURE. A rise that opens a window seeds the count
  // with its own high cycle, so each window covers whole high phases.
  always_comb begin
    hacc_next = hacc_reg;
    high_next = high_reg;
    if ((state_reg == IDLE) && rise) begin
      hacc_next = ACC_W'(1);
    end else if (window_done) begin
      high_next = hacc_reg[AVG_LOG2 +: CNT_W];
      hacc_next = ACC_W'(1);
    end else if ((state_reg == MEASURE) && s2_reg) begin
      hacc_next = hacc_reg + ACC_W'(1);
    end
    if (timeout) begin
      hacc_next = '0;
      high_next = '0;
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_square_freq_meter.sv
// Testbench for square_freq_meter (TIMEOUT=1000, AVG_LOG2=2).
// A period-list reference model predicts every result window.
module tb_square_freq_meter;

  localparam int CNT_W    = 24;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 1000;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             no_signal;
  logic [CNT_W-1:0] high_time;

  square_freq_meter #(
    .CNT_W(CNT_W),
    .AVG_LOG2(AVG_LOG2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .period(period),
    .period_vld(period_vld),
    .no_signal(no_signal),
    .high_time(high_time)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t exp_q[$];
  int   vld_cyc[$];
  exp_t mon_e;

  // Reference model: the list of periods between consecutive rises,
  // grouped into windows of NAVG periods.
  int m_acc, m_hacc, m_nper, m_prev_h, m_prev_l;
  bit m_have_prev;

  function automatic void model_clear();
    m_acc = 0;
    m_hacc = 0;
    m_nper = 0;
    m_have_prev = 0;
  endfunction

  function automatic void model_rise(int h, int l);
    exp_t e;
    if (m_have_prev) begin
      m_acc  += m_prev_h + m_prev_l;
      m_hacc += m_prev_h;
      m_nper++;
      if (m_nper == NAVG) begin
        e.p = m_acc / NAVG;
        e.h = m_hacc / NAVG;
        exp_q.push_back(e);
        m_acc = 0;
        m_hacc = 0;
        m_nper = 0;
      end
    end
    m_prev_h = h;
    m_prev_l = l;
    m_have_prev = 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one period (h high, l low), starting and ending at a negedge.
  task automatic drive_period(input int h, input int l);
    model_rise(h, l);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Monitor: each period_vld pulse must match the next predicted window.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n && period_vld) begin
      vld_cyc.push_back(cyc);
      check("vld_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        $display("vld @%0d: period=%0d (exp %0d) high_time=%0d", cyc, period, mon_e.p, high_time);
        check("period", 32'(period), 32'(mon_e.p));
`ifdef DUTY_MEAS_EN
        check("high_time", 32'(high_time), 32'(mon_e.h));
`else
        check("high_time", 32'(high_time), 32'd0);
`endif
        check("no_signal_on_vld", 32'(no_signal), 32'd0);
      end
    end
  end

  int nvld;

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_period", 32'(period), 32'd0);
    check("rst_vld", 32'(period_vld), 32'd0);
    check("rst_no_signal", 32'(no_signal), 32'd1);
    check("rst_high_time", 32'(high_time), 32'd0);
    rst_n = 1'b1;

    // Steady 10/10 square wave.
    repeat (9) drive_period(10, 10);
    check("steady_vld_count", 32'(vld_cyc.size()), 32'd2);
    if (vld_cyc.size() >= 2) check("steady_vld_gap", 32'(vld_cyc[1] - vld_cyc[0]), 32'd80);
    check("steady_no_signal", 32'(no_signal), 32'd0);

    // Loss of signal: the last rise, then low until the timeout.
    model_rise(10, 0);
    sig_in = 1'b1;
    repeat (10) @(negedge clk);
    sig_in = 1'b0;
    repeat (TIMEOUT - 8) @(negedge clk);
    check("pre_timeout_no_signal", 32'(no_signal), 32'd0);
    @(negedge clk);
    check("timeout_no_signal", 32'(no_signal), 32'd1);
    check("timeout_period", 32'(period), 32'd0);
    check("timeout_high_time", 32'(high_time), 32'd0);
    model_clear();

    // Period 30 after loss: four rises are not enough for a result.
    repeat (4) drive_period(15, 15);
    check("p30_still_no_signal", 32'(no_signal), 32'd1);
    check("p30_still_period0", 32'(period), 32'd0);

    // Window of 20,20,24,24 -> 22. The first call closes the 30 window.
    repeat (2) drive_period(10, 10);
    repeat (2) drive_period(12, 12);
    // Window of 20,20,20,23 -> 20 (truncation).
    repeat (3) drive_period(10, 10);
    drive_period(12, 11);
    // Minimum period 2.
    repeat (4) drive_period(1, 1);
    // Duty 6/14.
    repeat (4) drive_period(6, 14);
    // Randomized windows.
    for (int i = 0; i < 24; i++) begin
      drive_period(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)));
    end
    drive_period(5, 5);
    drive_period(5, 5);
    check("all_windows_seen", 32'(exp_q.size()), 32'd0);

    // Reset mid-window acts immediately and discards the partial window.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sig_in = 1'b0;
    #1;
    check("async_rst_period", 32'(period), 32'd0);
    check("async_rst_no_signal", 32'(no_signal), 32'd1);
    check("async_rst_vld", 32'(period_vld), 32'd0);
    check("async_rst_high_time", 32'(high_time), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    nvld = vld_cyc.size();
    repeat (4) drive_period(8, 8);
    check("post_rst_no_early_vld", 32'(vld_cyc.size()), 32'(nvld));
    check("post_rst_no_signal", 32'(no_signal), 32'd1);
    drive_period(8, 8);
    repeat (10) @(negedge clk);
    check("post_rst_vld_count", 32'(vld_cyc.size()), 32'(nvld + 1));
    check("post_rst_period", 32'(period), 32'd16);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
